// File: rtl/pixel_writer_pkg.sv
// ============================================================================
//  pixel_writer_pkg
//  Shared screen geometry, colour and request types for the pixel writer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pixel_writer_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t KEY_COLOUR_DEFAULT = 12'hF0F;

    typedef enum logic [1:0] {
        SRC_FLAT   = 2'd0,
        SRC_BBACK  = 2'd1,
        SRC_PLAYER = 2'd2,
        SRC_WIN    = 2'd3
    } rom_sel_t;

    // Request payload carried alongside the ROM access
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        rgb444_t    c;
        rom_sel_t   src;
    } pix_req_t;

    localparam int PIX_REQ_W = $bits(pix_req_t);

endpackage

`default_nettype wire

// File: rtl/pw_delay_line.sv
// ============================================================================
//  pw_delay_line
//  DEPTH-stage shift register for a valid bit plus W-bit payload. Only the
//  valid bits are reset; the payload is don't-care whenever its valid is low.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pw_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         any_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Shift valid bits one stage per clock; reset drops everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Shift payload alongside the valid bits
    always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign data_o      = data_q[DEPTH-1];
    assign any_valid_o = |valid_q;

endmodule

`default_nettype wire

// File: rtl/pixel_writer.sv
// ============================================================================
//  pixel_writer
//  Final draw stage: drives sprite/background ROM addresses, realigns each
//  pixel request with its ROM data, selects the colour and issues a
//  registered VGA write. One pixel per clock, latency ROM_LAT+1.
//  Optional build macro: PIXEL_WRITER_KEY_EN (colour-key transparency on
//  player and win-banner sprites).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int      ROM_LAT    = 2,
    parameter rgb444_t KEY_COLOUR = KEY_COLOUR_DEFAULT,
    parameter int      CNT_W      = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             plot,
    input  logic [8:0]       x,
    input  logic [7:0]       y,
    input  logic [11:0]      c,
    input  logic [1:0]       select_rom,
    input  logic             ld_bback,
    input  logic [16:0]      bback_addr,
    input  logic [14:0]      w_addr,
    input  logic [7:0]       p_addr,
    output logic [16:0]      bback_rom_addr,
    output logic [14:0]      w_rom_addr,
    output logic [7:0]       p_rom_addr,
    input  logic [11:0]      bback_q,
    input  logic [11:0]      w_q,
    input  logic [11:0]      p_q,
    output logic [8:0]       vga_x,
    output logic [7:0]       vga_y,
    output logic [11:0]      vga_colour,
    output logic             vga_plot,
    output logic [CNT_W-1:0] pix_count,
    output logic             busy
);

`ifdef PIXEL_WRITER_KEY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    // ROM addresses go straight through so the ROM sees them in the request cycle
    assign bback_rom_addr = bback_addr;
    assign w_rom_addr     = w_addr;
    assign p_rom_addr     = p_addr;

    // Erase requests force the board background regardless of select_rom
    rom_sel_t src_in;
    pix_req_t req_in;
    pix_req_t req_dl;
    logic     valid_dl;
    logic     any_valid_dl;

    assign src_in = ld_bback ? SRC_BBACK : rom_sel_t'(select_rom);
    assign req_in = '{x: x, y: y, c: c, src: src_in};

    pw_delay_line #(
        .DEPTH (ROM_LAT),
        .W     (PIX_REQ_W)
    ) u_delay (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (plot),
        .data_i      (req_in),
        .valid_o     (valid_dl),
        .data_o      (req_dl),
        .any_valid_o (any_valid_dl)
    );

    logic             out_valid_q;
    logic             vga_plot_q,   vga_plot_d;
    logic [8:0]       vga_x_q,      vga_x_d;
    logic [7:0]       vga_y_q,      vga_y_d;
    rgb444_t          vga_colour_q, vga_colour_d;
    logic [CNT_W-1:0] pix_count_q,  pix_count_d;
    rgb444_t          colour_sel;
    logic             in_range;
    logic             keyed;

    // Choose the final colour by the source resolved when the request entered
    always_comb begin
        colour_sel = req_dl.c;
        case (req_dl.src)
            SRC_FLAT:   colour_sel = req_dl.c;
            SRC_BBACK:  colour_sel = bback_q;
            SRC_PLAYER: colour_sel = p_q;
            SRC_WIN:    colour_sel = w_q;
            default:    colour_sel = req_dl.c;
        endcase
    end

    // Decide whether the aligned request becomes a real write and compute next outputs
    always_comb begin
        in_range     = (req_dl.x < 9'(SCREEN_W)) && (req_dl.y < 8'(SCREEN_H));
        keyed        = KEY_EN
                       && ((req_dl.src == SRC_PLAYER) || (req_dl.src == SRC_WIN))
                       && (colour_sel == KEY_COLOUR);
        vga_plot_d   = valid_dl && in_range && !keyed;
        vga_x_d      = valid_dl ? req_dl.x   : vga_x_q;
        vga_y_d      = valid_dl ? req_dl.y   : vga_y_q;
        vga_colour_d = valid_dl ? colour_sel : vga_colour_q;
        pix_count_d  = (vga_plot_d && (pix_count_q != '1)) ? pix_count_q + CNT_W'(1)
                                                           : pix_count_q;
    end

    // Output stage: register VGA write and the saturating pixel counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            pix_count_q  <= '0;
        end else begin
            out_valid_q  <= valid_dl;
            vga_plot_q   <= vga_plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign vga_plot   = vga_plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign pix_count  = pix_count_q;
    assign busy       = any_valid_dl | out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_writer.sv
// ============================================================================
//  tb_pixel_writer
//  Self-checking bench: directed cases plus random streams compared against
//  a queue-based reference model of the pixel writer. A second instance with
//  CNT_W=4 exercises counter saturation.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pixel_writer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        plot;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic [1:0]  select_rom;
    logic        ld_bback;
    logic [16:0] bback_addr;
    logic [14:0] w_addr;
    logic [7:0]  p_addr;
    logic [11:0] bback_q = '0;
    logic [11:0] w_q     = '0;
    logic [11:0] p_q     = '0;

    logic [16:0] bback_rom_addr;
    logic [14:0] w_rom_addr;
    logic [7:0]  p_rom_addr;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [11:0] vga_colour;
    logic        vga_plot;
    logic [16:0] pix_count;
    logic        busy;

    logic [16:0] s_bb_addr;
    logic [14:0] s_w_addr;
    logic [7:0]  s_p_addr;
    logic [8:0]  s_vga_x;
    logic [7:0]  s_vga_y;
    logic [11:0] s_vga_colour;
    logic        s_vga_plot;
    logic [3:0]  s_pix_count;
    logic        s_busy;

    always #5 clk = ~clk;

    pixel_writer #(.ROM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .c(c),
        .select_rom(select_rom), .ld_bback(ld_bback),
        .bback_addr(bback_addr), .w_addr(w_addr), .p_addr(p_addr),
        .bback_rom_addr(bback_rom_addr), .w_rom_addr(w_rom_addr), .p_rom_addr(p_rom_addr),
        .bback_q(bback_q), .w_q(w_q), .p_q(p_q),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .pix_count(pix_count), .busy(busy)
    );

    pixel_writer #(.ROM_LAT(LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .c(c),
        .select_rom(select_rom), .ld_bback(ld_bback),
        .bback_addr(bback_addr), .w_addr(w_addr), .p_addr(p_addr),
        .bback_rom_addr(s_bb_addr), .w_rom_addr(s_w_addr), .p_rom_addr(s_p_addr),
        .bback_q(bback_q), .w_q(w_q), .p_q(p_q),
        .vga_x(s_vga_x), .vga_y(s_vga_y), .vga_colour(s_vga_colour), .vga_plot(s_vga_plot),
        .pix_count(s_pix_count), .busy(s_busy)
    );

    // ROM contents: distinct functions so a wrong mux leg shows up
    function automatic logic [11:0] rom_bb(input logic [16:0] a);
        return a[11:0];
    endfunction
    function automatic logic [11:0] rom_w(input logic [14:0] a);
        return {a[3:0], a[11:4]};
    endfunction
    function automatic logic [11:0] rom_p(input logic [7:0] a);
        return {~a, a[3:0]};
    endfunction

    // Two-cycle synchronous ROMs (registered address + registered output)
    logic [16:0] bb_a1 = '0;
    logic [14:0] w_a1  = '0;
    logic [7:0]  p_a1  = '0;
    always @(posedge clk) begin
        bb_a1   <= bback_rom_addr;
        w_a1    <= w_rom_addr;
        p_a1    <= p_rom_addr;
        bback_q <= rom_bb(bb_a1);
        w_q     <= rom_w(w_a1);
        p_q     <= rom_p(p_a1);
    end

    // Reference model: each accepted request becomes an entry; the entry
    // captured LAT edges before the current one is what the outputs show now.
    typedef struct {
        logic        plot;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [11:0] col;
        logic        wr;
    } ent_t;

    ent_t        pipe[$];
    logic        exp_plot;
    logic [8:0]  exp_x;
    logic [7:0]  exp_y;
    logic [11:0] exp_col;
    int          exp_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef PIXEL_WRITER_KEY_EN
    localparam bit KEY_ON = 1'b1;
`else
    localparam bit KEY_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        exp_plot = 1'b0;
        exp_x    = '0;
        exp_y    = '0;
        exp_col  = '0;
        exp_cnt  = 0;
    endtask

    task automatic check_all();
        check("vga_plot",   {31'd0, vga_plot},   {31'd0, exp_plot});
        check("vga_x",      {23'd0, vga_x},      {23'd0, exp_x});
        check("vga_y",      {24'd0, vga_y},      {24'd0, exp_y});
        check("vga_colour", {20'd0, vga_colour}, {20'd0, exp_col});
        check("pix_count",  {15'd0, pix_count},  exp_cnt);
        check("sat_count",  {28'd0, s_pix_count}, (exp_cnt > 15) ? 15 : exp_cnt);
    endtask

    // One clock: check pass-through, capture request, advance model, compare
    task automatic step();
        ent_t e;
        int   src;
        logic bz;
        #1;
        check("bb_rom_addr", {15'd0, bback_rom_addr}, {15'd0, bback_addr});
        check("w_rom_addr",  {17'd0, w_rom_addr},     {17'd0, w_addr});
        check("p_rom_addr",  {24'd0, p_rom_addr},     {24'd0, p_addr});
        src = ld_bback ? 1 : int'(select_rom);
        case (src)
            0:       e.col = c;
            1:       e.col = rom_bb(bback_addr);
            2:       e.col = rom_p(p_addr);
            default: e.col = rom_w(w_addr);
        endcase
        e.plot = plot && !reset;
        e.x    = x;
        e.y    = y;
        e.wr   = e.plot && (x < 320) && (y < 240)
                 && !(KEY_ON && (src >= 2) && (e.col == 12'hF0F));
        @(posedge clk);
        #1;
        pipe.push_back(e);
        bz = 1'b0;
        foreach (pipe[i]) bz |= pipe[i].plot;
        exp_plot = 1'b0;
        if (pipe.size() > LAT) begin
            e = pipe.pop_front();
            if (e.plot) begin
                exp_x    = e.x;
                exp_y    = e.y;
                exp_col  = e.col;
                exp_plot = e.wr;
                if (e.wr) exp_cnt++;
            end
        end
        check("busy", {31'd0, busy}, {31'd0, bz});
        check_all();
    endtask

    task automatic drive(input logic p, input logic [8:0] xi, input logic [7:0] yi,
                         input logic [11:0] ci, input logic [1:0] sel, input logic ld,
                         input logic [16:0] bba, input logic [14:0] wa, input logic [7:0] pa);
        plot = p; x = xi; y = yi; c = ci; select_rom = sel; ld_bback = ld;
        bback_addr = bba; w_addr = wa; p_addr = pa;
    endtask

    task automatic drive_rand(input bit force_plot, input bit in_range);
        drive(force_plot ? 1'b1 : 1'($urandom_range(0, 1)),
              9'(in_range ? $urandom_range(0, 319) : $urandom_range(0, 339)),
              8'(in_range ? $urandom_range(0, 239) : $urandom_range(0, 255)),
              12'($urandom), 2'($urandom), 1'($urandom_range(0, 4) == 0),
              17'($urandom), 15'($urandom), 8'($urandom));
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, '0, 2'd0, 1'b0, '0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    int cnt_before;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 2'd0, 1'b0, '0, '0, '0);
        model_reset();
        #2;
        check_all();
        check("busy_reset", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Flat pixel
        drive(1'b1, 9'd10, 8'd20, 12'h0F0, 2'd0, 1'b0, '0, '0, '0);
        step();
        idle(4);
        check("flat_count", {15'd0, pix_count}, 32'd1);

        // Background has priority over the win banner
        drive(1'b1, 9'd5, 8'd6, 12'h000, 2'd3, 1'b1, 17'h00123, 15'h0456, 8'h00);
        step();
        idle(4);
        check("prio_colour", {20'd0, vga_colour}, 32'h123);

        // Out-of-range pixels are dropped
        cnt_before = exp_cnt;
        drive(1'b1, 9'd320, 8'd0, 12'hABC, 2'd0, 1'b0, '0, '0, '0);
        step();
        drive(1'b1, 9'd0, 8'd240, 12'hABC, 2'd0, 1'b0, '0, '0, '0);
        step();
        idle(4);
        check("range_count", {15'd0, pix_count}, cnt_before);

        // Player sprite pixel whose ROM data is the key colour
        drive(1'b1, 9'd7, 8'd8, 12'h000, 2'd2, 1'b0, '0, '0, 8'h0F);
        step();
        idle(4);

        // 100 back-to-back in-range plots
        cnt_before = exp_cnt;
        for (int i = 0; i < 100; i++) begin
            drive_rand(1'b1, 1'b1);
            step();
        end
        idle(LAT + 1);
        check("stream_count", {15'd0, pix_count}, cnt_before + 100);
        check("stream_idle", {31'd0, busy}, 32'd0);

        // Random traffic including drops
        for (int i = 0; i < 300; i++) begin
            drive_rand(1'b0, 1'b0);
            step();
        end

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1, 1'b1);
            step();
        end
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("busy_midreset", {31'd0, busy}, 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive_rand(1'b0, 1'b0);
            step();
        end
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
